mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single SDRAM memory controller between NREQ requesters
//  (e.g. instruction fetch and data port). It grants one requester at a time and drives the
//  controller's MStrobe/MemWrite. It tracks the controller's PReady busy window to detect
//  completion, returns a per-requester done pulse, and aborts hung transactions via a timeout.
// PARAMETERS
//  NREQ     2    number of requesters (2..8)
//  IDW      1    width of grant_id; must hold NREQ-1
//  TIMEOUT  64   max cycles in WAIT_BUSY+WAIT_DONE before abort (>= 20; controller wait state = 15)
// PORTS
//  clk         in   1     single clock; all state updates on posedge
//  reset       in   1     asynchronous, active-low reset (0 = reset)
//  req         in   NREQ  per-requester request level; held until matching done/err
//  we          in   NREQ  per-requester write(1)/read(0); sampled with req at grant
//  gnt         out  NREQ  one-hot grant; held from ISSUE through DONE
//  grant_id    out  IDW   index of granted requester; valid while |gnt
//  done        out  NREQ  one-cycle pulse to granted requester on successful completion
//  err         out  1     one-cycle pulse on timeout abort (same cycle gnt drops)
//  mem_strobe  out  1     to controller MStrobe
//  mem_write   out  1     to controller MemWrite; registered copy of we[grant]
//  mem_busy    in   1     from controller PReady (1 while controller is out of Idle)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; gnt=0, grant_id=0, done=0, err=0, mem_strobe=0,
//   mem_write=0; rr pointer=0; timeout counter=0. Release is synchronous to the next posedge.
//  States:
//   IDLE: if any req, pick the first set bit searching from rr pointer upward (wrap at NREQ);
//    register gnt/grant_id/mem_write=we[i] -> ISSUE. With no req, stay.
//   ISSUE: mem_strobe=1 for exactly this one cycle; clear counter -> WAIT_BUSY.
//   WAIT_BUSY: mem_strobe=0; wait for mem_busy=1 -> WAIT_DONE. Counter increments.
//   WAIT_DONE: wait for mem_busy=0 -> DONE. Counter keeps incrementing (not cleared).
//   DONE: done[grant_id]=1 for one cycle; gnt cleared at the exit edge; rr pointer=grant_id+1
//    mod NREQ -> IDLE.
//   Timeout: counter reaching TIMEOUT-1 in WAIT_BUSY or WAIT_DONE -> err=1 for one cycle, gnt
//    cleared, rr pointer advanced as in DONE, -> IDLE. done is not pulsed.
//  Outputs are registered (Moore); mem_strobe is decoded from state==ISSUE.
//  Latency: req to mem_strobe = 2 cycles (IDLE decision edge, ISSUE). mem_busy fall to done = 1 cycle.
//   Minimum IDLE->IDLE turnaround = 5 cycles. A new grant may not be issued in the DONE cycle.
//  Fairness: a requester holding req continuously waits at most NREQ-1 other transactions.
//  req deasserted mid-transaction is ignored; the transaction completes and done still pulses.
//  mem_write and grant_id are stable from ISSUE until leaving DONE or the timeout cycle.
//  mem_busy=1 while in IDLE (stale controller) is ignored; no strobe is issued until IDLE
//   exits via a request. Same-cycle arrival of multiple req bits is resolved by the rr rule.
//  The controller updates on negedge clk; mem_busy is sampled on posedge only. No extra
//   synchronizer is required (same clock).
//  Illegal state encodings -> IDLE with outputs cleared.
// TESTING
//  1 Single read: req=2'b01, we=0; model busy for 17 cycles -> one strobe pulse, mem_write=0,
//    gnt=01 held, done[0] one cycle after busy falls, gnt=0 after.
//  2 Contention: req=2'b11 from reset, held -> grants 0,1,0,1 in order, never two consecutive
//    grants to one requester, one done per transaction.
//  3 Write path: req[1]=1, we[1]=1 -> mem_write=1 from ISSUE to DONE, grant_id=1, done=2'b10.
//  4 Timeout: model never asserts busy, TIMEOUT=64 -> err pulses 64 cycles after strobe,
//    no done, gnt=0, next pending requester granted.
//  5 Reset mid-operation: drive reset=0 while in WAIT_DONE -> all outputs 0 immediately
//    (no clock edge), IDLE after release, no done or err.
//  6 Early req drop: req[0] falls during WAIT_DONE -> transaction completes, done[0] pulses once.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one SDRAM controller between NREQ requesters.
// It issues a one-cycle strobe, follows the controller busy window, and aborts after TIMEOUT cycles.
module mem_arbiter #(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] we,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  grant_id,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            mem_strobe,
  output logic            mem_write,
  input  logic            mem_busy
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic [IDW-1:0]  id_nxt, rr, rr_nxt, rr_adv, pick, idx;
  logic            wr_nxt, err_nxt, pick_vld, timeout_hit;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;

  // Search upward from the rr pointer; lower offsets overwrite later, so the nearest one wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = IDW'((int'(rr) + k) % NREQ);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  assign rr_adv      = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT-1));
  assign mem_strobe  = (state == ISSUE);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = grant_id;
    wr_nxt    = mem_write;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    done_nxt  = '0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_nxt       = '0;
          gnt_nxt[pick] = 1'b1;
          id_nxt        = pick;
          wr_nxt        = we[pick];
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        cnt_nxt = cnt_inc;
        // Timeout wins over a busy edge arriving in the same cycle.
        if (timeout_hit) begin
          err_nxt   = 1'b1;
          gnt_nxt   = '0;
          rr_nxt    = rr_adv;
          state_nxt = IDLE;
        end else if (state == WAIT_BUSY && mem_busy) begin
          state_nxt = WAIT_DONE;
        end else if (state == WAIT_DONE && !mem_busy) begin
          done_nxt           = '0;
          done_nxt[grant_id] = 1'b1;
          state_nxt          = DONE;
        end
      end
      DONE: begin
        gnt_nxt   = '0;
        rr_nxt    = rr_adv;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        id_nxt    = '0;
        wr_nxt    = 1'b0;
        rr_nxt    = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= '0;
      grant_id  <= '0;
      done      <= '0;
      err       <= 1'b0;
      mem_write <= 1'b0;
      rr        <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      grant_id  <= id_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      mem_write <= wr_nxt;
      rr        <= rr_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small negedge controller model driving mem_busy.
module tb_mem_arbiter;
  localparam int NREQ = 2, IDW = 1, TIMEOUT = 64;

  logic            clk = 1'b0, reset = 1'b0;
  logic [NREQ-1:0] req = '0, we = '0;
  logic [NREQ-1:0] gnt, done;
  logic [IDW-1:0]  grant_id;
  logic            err, mem_strobe, mem_write;
  logic            mem_busy = 1'b0;

  int n_chk = 0, n_fail = 0;
  int busy_len = 17, bcnt = 0;
  bit stall = 1'b0;
  int done_cnt[2] = '{0, 0};
  int err_cnt = 0, strobe_cnt = 0;
  int grants[$];

  always #5 clk = ~clk;

  mem_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .gnt(gnt), .grant_id(grant_id),
    .done(done), .err(err), .mem_strobe(mem_strobe), .mem_write(mem_write), .mem_busy(mem_busy)
  );

  // Controller stand-in: busy for busy_len cycles after seeing a strobe, or never when stalled.
  always @(negedge clk) begin
    if (!reset) begin
      mem_busy = 1'b0;
      bcnt     = 0;
    end else if (bcnt != 0) begin
      bcnt--;
      if (bcnt == 0) mem_busy = 1'b0;
    end else if (mem_strobe && !stall) begin
      mem_busy = 1'b1;
      bcnt     = busy_len;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      if (mem_strobe) begin
        strobe_cnt++;
        grants.push_back(int'(grant_id));
      end
      if (done[0]) done_cnt[0]++;
      if (done[1]) done_cnt[1]++;
      if (err) err_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    we    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_end(input int max, output int c);
    c = 0;
    while (!((|done) || err) && c < max) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    int c, d0, d1, e0, s0;

    // reset state
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_id", 32'(grant_id), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_strobe", 32'(mem_strobe), 0);
    chk("rst_write", 32'(mem_write), 0);
    reset = 1'b1;
    @(negedge clk);

    // single read
    busy_len = 17;
    req = 2'b01; we = 2'b00;
    @(negedge clk);
    chk("t1_strobe", 32'(mem_strobe), 1);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_write", 32'(mem_write), 0);
    chk("t1_id", 32'(grant_id), 0);
    @(negedge clk);
    chk("t1_strobe_1cyc", 32'(mem_strobe), 0);
    wait_end(100, c);
    chk("t1_lat", c + 1, 18);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_gnt_held", 32'(gnt), 32'h1);
    chk("t1_err", 32'(err), 0);
    req = 2'b00;
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_gnt_clr", 32'(gnt), 0);
    chk("t1_nstrobe", strobe_cnt, 1);

    // contention from reset
    do_reset();
    grants.delete();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    busy_len = 3;
    req = 2'b11;
    c = 0;
    while ((done_cnt[0] - d0) + (done_cnt[1] - d1) < 4 && c < 300) begin
      @(negedge clk);
      c++;
    end
    req = 2'b00;
    chk("t2_ngrants", grants.size(), 4);
    if (grants.size() >= 4) begin
      chk("t2_g0", grants[0], 0);
      chk("t2_g1", grants[1], 1);
      chk("t2_g2", grants[2], 0);
      chk("t2_g3", grants[3], 1);
    end
    chk("t2_done0", done_cnt[0] - d0, 2);
    chk("t2_done1", done_cnt[1] - d1, 2);
    repeat (3) @(negedge clk);

    // write path on requester 1
    busy_len = 4;
    req = 2'b10; we = 2'b10;
    @(negedge clk);
    chk("t3_strobe", 32'(mem_strobe), 1);
    chk("t3_id", 32'(grant_id), 1);
    chk("t3_gnt", 32'(gnt), 32'h2);
    chk("t3_write", 32'(mem_write), 1);
    wait_end(50, c);
    chk("t3_done", 32'(done), 32'h2);
    chk("t3_write_done", 32'(mem_write), 1);
    chk("t3_id_done", 32'(grant_id), 1);
    req = 2'b00; we = 2'b00;
    @(negedge clk);
    chk("t3_done_pulse", 32'(done), 0);

    // timeout with both pending
    stall = 1'b1;
    e0 = err_cnt; d0 = done_cnt[0];
    req = 2'b11;
    @(negedge clk);
    chk("t4_strobe", 32'(mem_strobe), 1);
    chk("t4_id", 32'(grant_id), 0);
    wait_end(100, c);
    stall = 1'b0;
    busy_len = 3;
    chk("t4_lat", c, 64);
    chk("t4_err", 32'(err), 1);
    chk("t4_gnt", 32'(gnt), 0);
    chk("t4_nodone", 32'(done), 0);
    @(negedge clk);
    chk("t4_err_pulse", 32'(err), 0);
    chk("t4_next_strobe", 32'(mem_strobe), 1);
    chk("t4_next_id", 32'(grant_id), 1);
    req = 2'b00;
    wait_end(50, c);
    chk("t4_next_done", 32'(done), 32'h2);
    @(negedge clk);
    chk("t4_errcnt", err_cnt - e0, 1);
    chk("t4_done0", done_cnt[0] - d0, 0);

    // async reset while in WAIT_DONE
    busy_len = 17;
    req = 2'b10; we = 2'b10;
    @(negedge clk);
    chk("t5_strobe", 32'(mem_strobe), 1);
    repeat (5) @(negedge clk);
    d0 = done_cnt[0]; d1 = done_cnt[1]; e0 = err_cnt; s0 = strobe_cnt;
    #2 reset = 1'b0;
    #1;
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_id", 32'(grant_id), 0);
    chk("t5_write", 32'(mem_write), 0);
    chk("t5_strobe0", 32'(mem_strobe), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_err", 32'(err), 0);
    req = 2'b00; we = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    chk("t5_nodone", (done_cnt[0] - d0) + (done_cnt[1] - d1), 0);
    chk("t5_noerr", err_cnt - e0, 0);
    chk("t5_nostrobe", strobe_cnt - s0, 0);
    chk("t5_idle_gnt", 32'(gnt), 0);

    // req dropped mid-transaction
    d0 = done_cnt[0];
    req = 2'b01;
    @(negedge clk);
    chk("t6_strobe", 32'(mem_strobe), 1);
    repeat (5) @(negedge clk);
    req = 2'b00;
    wait_end(50, c);
    chk("t6_done", 32'(done), 32'h1);
    @(negedge clk);
    chk("t6_done_pulse", 32'(done), 0);
    repeat (10) @(negedge clk);
    chk("t6_done_once", done_cnt[0] - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
